global_avg_pool_acc: RTL and testbench
======================================

GLOBAL_AVG_POOL_ACC -- requirements
Module: global_avg_pool_acc

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of 8-bit channels per input and output beat.
REQ-002 The block SHALL have parameter CHANNELS, default 64, giving the total channel count; CHANNELS is a multiple of LANES, and G = CHANNELS/LANES.
REQ-003 The block SHALL have parameter SPATIAL, default 196, giving the pixels per channel (14x14).
REQ-004 The block SHALL have parameter ACC_W, default 24, giving the per-channel accumulator width; ACC_W >= 9+clog2(SPATIAL).
REQ-005 The block SHALL have parameter RECIP, default 334, giving round(2^16/SPATIAL) as an unsigned Q0.16 reciprocal.
REQ-006 The block SHALL have parameter SIGNED, default 0: 0 = unsigned bytes, 1 = two's-complement bytes.
REQ-007 The block SHALL have parameter ROUND, default 0: 0 = truncate (floor), 1 = add 2^15 before the >>16.
REQ-008 The block SHALL have port clk, input, 1 bit: clock, all state on the rising edge.
REQ-009 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-010 The block SHALL have port start, input, 1 bit: begin a pooling pass; sampled only in IDLE.
REQ-011 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 8*LANES): the input stream; lane k is in_data[8k+7:8k].
REQ-012 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 8*LANES) and out_last (output, 1): the averaged output stream.
REQ-013 The block SHALL have ports busy (output, 1), high outside IDLE, and done (output, 1), a one-cycle pulse at pass end.

Function
REQ-020 FSM states SHALL be IDLE, ACCUM and DRAIN; start=1 in IDLE moves to ACCUM on the next edge, and start SHALL be ignored in ACCUM and DRAIN.
REQ-021 in_ready SHALL be 1 only in ACCUM; a beat is accepted when in_valid && in_ready, and in_valid outside ACCUM SHALL have no effect.
REQ-022 Input order SHALL be pixel-major and group-minor: beat n carries group g = n mod G and pixel p = n div G, and lane k maps to channel g*LANES+k.
REQ-023 Accumulator storage SHALL be a G x (LANES*ACC_W) array with single-cycle read-modify-write; a back-to-back beat to the same group (G=1) SHALL see the updated value.
REQ-024 For pixel p=0 the accumulator SHALL be written with the extended byte, overwriting any old value, so no clear cycles are needed; for p>0 it SHALL be written with acc + byte.
REQ-025 Byte extension SHALL be zero-extension when SIGNED=0 and sign-extension when SIGNED=1.
REQ-026 Group and pixel counters SHALL wrap g at G-1 and advance p; acceptance of beat SPATIAL*G-1 SHALL move to DRAIN on the same edge.
REQ-027 Each result SHALL be res = (acc*RECIP + (ROUND ? 2^15 : 0)) >>> 16, computed at full width: ACC_W+17 bits, signed if SIGNED=1, using an arithmetic shift.
REQ-028 Each result SHALL saturate to [0,255] when SIGNED=0 and to [-128,127] when SIGNED=1; out_data lane k carries channel g*LANES+k.
REQ-029 DRAIN SHALL emit G beats in group order 0..G-1 from a registered output; the first out_valid SHALL occur on the cycle after DRAIN entry.
REQ-030 While out_valid && !out_ready, out_data, out_last and out_valid SHALL hold stable.
REQ-031 out_last SHALL be 1 only on beat G-1.
REQ-032 When the last beat is accepted, the block SHALL return to IDLE and pulse done=1 for exactly one cycle on the following cycle; out_valid SHALL be 0 in IDLE and ACCUM.
REQ-033 A new start SHALL be accepted on the cycle after return to IDLE, and the result of a new pass SHALL be independent of the previous pass.

Reset
REQ-040 While reset_n=0, the block SHALL be in IDLE with counters 0 and in_ready, out_valid, out_last, out_data, busy and done all 0.
REQ-041 Accumulator contents SHALL not require reset, by REQ-024.
REQ-042 Reset asserted mid-ACCUM or mid-DRAIN SHALL abort the pass with no further output beats, and the next start SHALL begin a clean pass.

Verification
REQ-050 The bench SHALL cover: defaults, ROUND=0, all bytes 10 for 196x16 beats -> acc=1960, every out byte 9; same with ROUND=1 -> every out byte 10.
REQ-051 The bench SHALL cover: defaults, all bytes 255 -> acc=49980, every out byte 254 (0xFE), no saturation triggered.
REQ-052 The bench SHALL cover: SIGNED=1, all bytes 0x80 -> acc=-25088, res=-128, out bytes 0x80; with all bytes 0x7F -> out bytes 0x7E.
REQ-053 The bench SHALL cover: out_ready low for 5 cycles while output beat 3 is valid -> data held stable, 16 beats total, out_last only on beat 15, done 1 cycle after beat 15 is accepted.
REQ-054 The bench SHALL cover: reset asserted after 100 pixels -> all outputs 0 and busy 0; new pass with all bytes 20 -> every out byte 19 (ROUND=0).
REQ-055 The bench SHALL cover: LANES=1, CHANNELS=1, SPATIAL=4, RECIP=16384, in_valid every cycle with bytes 1,2,3,4 -> one output beat 2 with out_last=1; also start during ACCUM and in_valid in IDLE -> ignored.

Source files
------------

// File: rtl/global_avg_pool_acc.sv
// Global average pooling: accumulates SPATIAL pixels per channel, LANES channels per beat,
// then streams out saturated averages (acc * RECIP >> 16), one group of LANES channels per beat.
module global_avg_pool_acc #(
  parameter int LANES    = 4,
  parameter int CHANNELS = 64,
  parameter int SPATIAL  = 196,
  parameter int ACC_W    = 24,
  parameter int RECIP    = 334,
  parameter int SIGNED   = 0,
  parameter int ROUND    = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int G  = CHANNELS / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int PW = (SPATIAL > 1) ? $clog2(SPATIAL) : 1;
  localparam int RW = $clog2(G + 1);
  localparam int MW = ACC_W + 17;
  localparam int WW = LANES * ACC_W;

  localparam logic signed [MW-1:0] S_MAX  = 127;
  localparam logic signed [MW-1:0] S_MIN  = -128;
  localparam logic signed [MW-1:0] U_MAX  = 255;
  localparam logic signed [MW-1:0] ZERO   = 0;
  localparam logic signed [MW-1:0] RND    = (ROUND != 0) ? 32768 : 0;
  localparam logic signed [MW-1:0] RECIPX = RECIP;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     g_q, g_d;
  logic [PW-1:0]     p_q, p_d;
  logic [RW-1:0]     rd_g_q, rd_g_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic [8*LANES-1:0] out_data_q, out_data_d;

  // Depth rounded up to a power of two so the index width always matches, even for G=1.
  logic [WW-1:0]      acc_mem [2**GW];
  logic [WW-1:0]      acc_rd, acc_wr, drain_rd;
  logic [8*LANES-1:0] drain_res;
  logic [GW-1:0]      drain_idx;
  logic               accept, load;

  function automatic logic [7:0] avg_byte(input logic [ACC_W-1:0] acc);
    logic signed [MW-1:0] acc_x;
    logic signed [MW-1:0] scaled;
    logic [7:0]           res;
    if (SIGNED != 0) acc_x = {{17{acc[ACC_W-1]}}, acc};
    else             acc_x = {17'b0, acc};
    scaled = (acc_x * RECIPX + RND) >>> 16;
    res = scaled[7:0];
    if (SIGNED != 0) begin
      if (scaled > S_MAX)      res = 8'h7F;
      else if (scaled < S_MIN) res = 8'h80;
    end else begin
      if (scaled > U_MAX)      res = 8'hFF;
      else if (scaled < ZERO)  res = 8'h00;
    end
    return res;
  endfunction

  assign accept    = in_valid && (state_q == ACCUM);
  assign acc_rd    = acc_mem[g_q];
  assign drain_idx = (rd_g_q < RW'(G)) ? GW'(rd_g_q) : '0;
  assign drain_rd  = acc_mem[drain_idx];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0]       lane_byte;
      logic [ACC_W-1:0] lane_ext;
      assign lane_byte = in_data[8*gi +: 8];
      assign lane_ext  = (SIGNED != 0) ? {{(ACC_W-8){lane_byte[7]}}, lane_byte}
                                       : {{(ACC_W-8){1'b0}}, lane_byte};
      // Pixel 0 overwrites, so stale sums from an earlier pass never leak in.
      assign acc_wr[gi*ACC_W +: ACC_W] = (p_q == '0) ? lane_ext
                                       : acc_rd[gi*ACC_W +: ACC_W] + lane_ext;
      assign drain_res[8*gi +: 8] = avg_byte(drain_rd[gi*ACC_W +: ACC_W]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (accept) acc_mem[g_q] <= acc_wr;
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    p_d         = p_q;
    rd_g_d      = rd_g_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          g_d     = '0;
          p_d     = '0;
          rd_g_d  = '0;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (g_q == GW'(G - 1)) begin
            g_d = '0;
            if (p_q == PW'(SPATIAL - 1)) begin
              p_d     = '0;
              rd_g_d  = '0;
              state_d = DRAIN;
            end else begin
              p_d = p_q + PW'(1);
            end
          end else begin
            g_d = g_q + GW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end
        end
        // Refill the output register whenever it is empty or being drained this cycle.
        load = (rd_g_q < RW'(G)) && (!out_valid_q || out_ready);
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = drain_res;
          out_last_d  = (rd_g_q == RW'(G - 1));
          rd_g_d      = rd_g_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      g_q         <= '0;
      p_q         <= '0;
      rd_g_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      p_q         <= p_d;
      rd_g_q      <= rd_g_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_global_avg_pool_acc.sv
// Directed bench: three default-geometry instances (ROUND=0, ROUND=1, SIGNED=1) share one
// input stream; a fourth single-lane instance covers the tiny SPATIAL=4 case.
module tb_global_avg_pool_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, in_valid, out_ready;
  logic [31:0] in_data;
  logic        a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
  logic        b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
  logic        c_in_ready, c_out_valid, c_out_last, c_busy, c_done;
  logic [31:0] a_out_data, b_out_data, c_out_data;

  logic       d_start, d_in_valid, d_out_ready;
  logic [7:0] d_in_data, d_out_data;
  logic       d_in_ready, d_out_valid, d_out_last, d_busy, d_done;

  int checks = 0;
  int errors = 0;

  global_avg_pool_acc dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy), .done(a_done));

  global_avg_pool_acc #(.ROUND(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy), .done(b_done));

  global_avg_pool_acc #(.SIGNED(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .out_last(c_out_last), .busy(c_busy), .done(c_done));

  global_avg_pool_acc #(.LANES(1), .CHANNELS(1), .SPATIAL(4), .RECIP(16384)) dut_d (
    .clk(clk), .reset_n(reset_n), .start(d_start), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .out_last(d_out_last), .busy(d_busy), .done(d_done));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pat 0: every byte = val; pat 1: byte = channel index.
  function automatic logic [7:0] pat_byte(input int pat, input logic [7:0] val, input int g, input int k);
    return (pat == 0) ? val : 8'(g * 4 + k);
  endfunction

  // For the channel-index pattern: floor(196c*334/2^16) = c-1 (c>0); with rounding it is c.
  function automatic logic [7:0] exp_byte(input int which, input int pat, input logic [7:0] e, input int ch);
    if (pat == 0) return e;
    if (which == 1) return 8'(ch);
    return (ch == 0) ? 8'd0 : 8'(ch - 1);
  endfunction

  task automatic feed(input int pat, input logic [7:0] val, input int npix);
    int accepted;
    int budget;
    logic rdy;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL feed_enter busy=%b in_ready=%b out_valid=%b done=%b required 1 1 0 0",
               a_busy, a_in_ready, a_out_valid, a_done);
    end
    accepted = 0;
    budget   = 0;
    while (accepted < npix * 16 && budget < npix * 16 + 50) begin
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) in_data[8*k +: 8] = pat_byte(pat, val, accepted % 16, k);
      rdy = a_in_ready;
      tick();
      budget++;
      if (rdy) accepted++;
    end
    in_valid = 1'b0;
    checks++;
    if (accepted != npix * 16) begin
      errors++;
      $display("FAIL feed_count accepted=%0d required %0d", accepted, npix * 16);
    end
    $display("feed pat=%0d val=%h beats=%0d", pat, val, accepted);
  endtask

  task automatic drain(input int pat, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] ec, input int stall_beat);
    int waited;
    logic [31:0] xa, xb, xc, hold;
    out_ready = 1'b1;
    checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_entry out_valid=%b busy=%b required 0 1", a_out_valid, a_busy);
    end
    for (int beat = 0; beat < 16; beat++) begin
      waited = 0;
      while (a_out_valid !== 1'b1 && waited < 20) begin
        tick();
        waited++;
      end
      checks++;
      if (a_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_valid_timeout beat=%0d out_valid=%b required 1", beat, a_out_valid);
        break;
      end
      if (beat == 0) begin
        checks++;
        if (waited !== 1) begin
          errors++;
          $display("FAIL first_valid_latency cycles=%0d required 1", waited);
        end
      end
      for (int k = 0; k < 4; k++) begin
        xa[8*k +: 8] = exp_byte(0, pat, ea, beat * 4 + k);
        xb[8*k +: 8] = exp_byte(1, pat, eb, beat * 4 + k);
        xc[8*k +: 8] = exp_byte(2, pat, ec, beat * 4 + k);
      end
      $display("beat %0d a=%h b=%h c=%h last=%b", beat, a_out_data, b_out_data, c_out_data, a_out_last);
      checks++;
      if (a_out_data !== xa || a_out_last !== (beat == 15) || a_done !== 1'b0) begin
        errors++;
        $display("FAIL data_a beat=%0d got=%h last=%b done=%b required %h %b 0",
                 beat, a_out_data, a_out_last, a_done, xa, (beat == 15));
      end
      checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== xb || b_out_last !== (beat == 15)) begin
        errors++;
        $display("FAIL data_b_round beat=%0d got=%h v=%b last=%b required %h", beat, b_out_data,
                 b_out_valid, b_out_last, xb);
      end
      checks++;
      if (c_out_valid !== 1'b1 || c_out_data !== xc || c_out_last !== (beat == 15)) begin
        errors++;
        $display("FAIL data_c_signed beat=%0d got=%h v=%b last=%b required %h", beat, c_out_data,
                 c_out_valid, c_out_last, xc);
      end
      if (beat == stall_beat) begin
        out_ready = 1'b0;
        hold = a_out_data;
        for (int s = 0; s < 5; s++) begin
          tick();
          checks++;
          if (a_out_valid !== 1'b1 || a_out_data !== hold || a_out_last !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cycle=%0d valid=%b data=%h last=%b required 1 %h 0",
                     s, a_out_valid, a_out_data, a_out_last, hold);
          end
        end
        out_ready = 1'b1;
      end
      tick();
    end
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_out_valid !== 1'b0 || b_done !== 1'b1 || c_done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse done=%b/%b/%b busy=%b out_valid=%b required 1/1/1 0 0",
               a_done, b_done, c_done, a_busy, a_out_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    d_start = 1'b0; d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({a_in_ready, a_out_valid, a_out_last, a_busy, a_done} !== 5'b0 || a_out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs flags=%b data=%h required 00000 0",
               {a_in_ready, a_out_valid, a_out_last, a_busy, a_done}, a_out_data);
    end
    checks++;
    if ({d_in_ready, d_out_valid, d_out_last, d_busy, d_done} !== 5'b0 || d_out_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs_small flags=%b data=%h required 00000 0",
               {d_in_ready, d_out_valid, d_out_last, d_busy, d_done}, d_out_data);
    end
    reset_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_small();
    d_in_valid = 1'b1;
    d_in_data  = 8'hAA;
    tick();
    tick();
    checks++;
    if (d_in_ready !== 1'b0 || d_busy !== 1'b0) begin
      errors++;
      $display("FAIL small_idle_ignore in_ready=%b busy=%b required 0 0", d_in_ready, d_busy);
    end
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    checks++;
    if (d_busy !== 1'b1 || d_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL small_start busy=%b in_ready=%b required 1 1", d_busy, d_in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      d_in_data  = 8'(i + 1);
      d_in_valid = 1'b1;
      d_start    = (i == 1);
      tick();
    end
    d_in_valid = 1'b0;
    d_start    = 1'b0;
    checks++;
    if (d_out_valid !== 1'b0 || d_busy !== 1'b1) begin
      errors++;
      $display("FAIL small_drain_entry out_valid=%b busy=%b required 0 1", d_out_valid, d_busy);
    end
    tick();
    $display("small beat data=%h last=%b", d_out_data, d_out_last);
    checks++;
    if (d_out_valid !== 1'b1 || d_out_data !== 8'd2 || d_out_last !== 1'b1) begin
      errors++;
      $display("FAIL small_result valid=%b data=%h last=%b required 1 02 1", d_out_valid, d_out_data, d_out_last);
    end
    tick();
    checks++;
    if (d_done !== 1'b1 || d_out_valid !== 1'b0 || d_busy !== 1'b0) begin
      errors++;
      $display("FAIL small_done done=%b out_valid=%b busy=%b required 1 0 0", d_done, d_out_valid, d_busy);
    end
    tick();
    checks++;
    if (d_done !== 1'b0 || d_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL small_done_width done=%b out_valid=%b required 0 0", d_done, d_out_valid);
    end
  endtask

  task automatic test_channel_pattern();
    feed(1, 8'h00, 196);
    drain(1, 8'h00, 8'h00, 8'h00, -1);
  endtask

  task automatic test_const10();
    feed(0, 8'd10, 196);
    drain(0, 8'd9, 8'd10, 8'd9, -1);
  endtask

  task automatic test_back_pressure();
    feed(0, 8'hFF, 196);
    drain(0, 8'hFE, 8'hFF, 8'hFF, 3);
  endtask

  task automatic test_signed_extremes();
    feed(0, 8'h80, 196);
    drain(0, 8'h7F, 8'h80, 8'h80, -1);
    feed(0, 8'h7F, 196);
    drain(0, 8'h7E, 8'h7F, 8'h7E, -1);
  endtask

  task automatic test_reset_mid_pass();
    feed(0, 8'd33, 100);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_in_ready, a_out_valid, a_out_last, a_busy, a_done, b_busy, c_busy} !== 7'b0 || a_out_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs flags=%b data=%h required 0000000 0",
               {a_in_ready, a_out_valid, a_out_last, a_busy, a_done, b_busy, c_busy}, a_out_data);
    end
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_quiet out_valid=%b busy=%b required 0 0", a_out_valid, a_busy);
    end
    feed(0, 8'd20, 196);
    drain(0, 8'd19, 8'd20, 8'd19, -1);
  endtask

  initial begin
    test_reset();
    test_small();
    test_channel_pattern();
    test_const10();
    test_back_pressure();
    test_signed_extremes();
    test_reset_mid_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
